systolic_setup: RTL and testbench

Input skew stage between the global buffers A/B and the systolic PE array. It captures one 8-lane word per cycle from buffer A (row operands) and buffer B (column operands) and zeroes bubble cycles. It then delays lane i by i cycles, so that operands enter the array as a diagonal wavefront. It is driven by the controller's ensys/bubble outputs, and its skewed outputs feed the left and top edges of the PE array directly.

---
 rtl/systolic_setup.sv | 101 ++++++++++
 tb/tb_systolic_setup.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_setup.sv
// systolic_setup: input skew stage between the A/B global buffers and the
// systolic PE array. Each accepted 8-lane word is split so that lane i
// reaches the array i cycles later than lane 0, forming a diagonal wavefront.
// Bubble and idle cycles inject zeros with valid low, so the array never
// sees stale operands.
module systolic_setup #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BUF_LAT    = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ensys_i,
  input  logic                          bubble_i,
  input  logic                          flush_i,
  input  logic [LANES*DATA_WIDTH-1:0]   data_a_i,
  input  logic [LANES*DATA_WIDTH-1:0]   data_b_i,
  output logic [LANES*DATA_WIDTH-1:0]   a_o,
  output logic [LANES*DATA_WIDTH-1:0]   b_o,
  output logic [LANES-1:0]              valid_a_o,
  output logic [LANES-1:0]              valid_b_o,
  output logic                          busy_o
);

  logic             bub_d;
  logic             in_valid;
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_busy;

  // Delay the bubble flag by the buffer read latency so it lines up with
  // the data slot that was never requested.
  if (BUF_LAT == 0) begin : g_no_buf_lat
    assign bub_d = bubble_i;
  end else begin : g_buf_lat
    logic [BUF_LAT-1:0] bub_sr;

    // Bubble delay line, cleared by reset and by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        bub_sr <= '0;
      end else if (flush_i) begin
        bub_sr <= '0;
      end else begin
        bub_sr[0] <= bubble_i;
        for (int k = 1; k < BUF_LAT; k++) begin
          bub_sr[k] <= bub_sr[k-1];
        end
      end
    end

    assign bub_d = bub_sr[BUF_LAT-1];
  end

  assign in_valid = ensys_i & ~bub_d;

  // Lane i owns a private chain of i+1 registers for A, B and valid, so the
  // triangle of storage is exactly what the skew needs and nothing more.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_pipe [0:i];
    logic [DATA_WIDTH-1:0] b_pipe [0:i];
    logic [i:0]            v_pipe;

    // Stage 0 captures the lane (or zero when not accepted); later stages
    // shift every cycle so the wavefront drains without ensys.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j <= i; j++) begin
          a_pipe[j] <= '0;
          b_pipe[j] <= '0;
        end
        v_pipe <= '0;
      end else if (flush_i) begin
        for (int j = 0; j <= i; j++) begin
          a_pipe[j] <= '0;
          b_pipe[j] <= '0;
        end
        v_pipe <= '0;
      end else begin
        a_pipe[0] <= in_valid ? data_a_i[DATA_WIDTH*i +: DATA_WIDTH] : '0;
        b_pipe[0] <= in_valid ? data_b_i[DATA_WIDTH*i +: DATA_WIDTH] : '0;
        v_pipe[0] <= in_valid;
        for (int j = 1; j <= i; j++) begin
          a_pipe[j] <= a_pipe[j-1];
          b_pipe[j] <= b_pipe[j-1];
          v_pipe[j] <= v_pipe[j-1];
        end
      end
    end

    assign a_o[DATA_WIDTH*i +: DATA_WIDTH] = a_pipe[i];
    assign b_o[DATA_WIDTH*i +: DATA_WIDTH] = b_pipe[i];
    assign lane_valid[i] = v_pipe[i];
    assign lane_busy[i]  = |v_pipe;
  end

  // A and B always move together, so one valid chain serves both edges.
  assign valid_a_o = lane_valid;
  assign valid_b_o = lane_valid;
  assign busy_o    = ensys_i | (|lane_busy);

endmodule

// File: tb/tb_systolic_setup.sv
// tb_systolic_setup: randomized and directed stimulus for systolic_setup,
// checked every cycle against a history-based model of the wavefront.
module tb_systolic_setup;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int BL    = 1;
  localparam int W     = LANES*DW;
  localparam int MAXC  = 2048;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic ensys_i = 1'b0, bubble_i = 1'b0, flush_i = 1'b0;
  logic [W-1:0] data_a_i = '0, data_b_i = '0;
  logic [W-1:0] a_o, b_o;
  logic [LANES-1:0] valid_a_o, valid_b_o;
  logic busy_o;

  int tests_run = 0;
  int failures  = 0;
  int cyc = 0;

  logic         ens_h [0:MAXC-1];
  logic         bub_h [0:MAXC-1];
  logic         fl_h  [0:MAXC-1];
  logic [W-1:0] a_h   [0:MAXC-1];
  logic [W-1:0] b_h   [0:MAXC-1];

  logic [W-1:0]     ea, eb;
  logic [LANES-1:0] ev;
  logic             ebusy;

  systolic_setup #(.LANES(LANES), .DATA_WIDTH(DW), .BUF_LAT(BL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ensys_i(ensys_i), .bubble_i(bubble_i),
    .flush_i(flush_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .a_o(a_o), .b_o(b_o), .valid_a_o(valid_a_o), .valid_b_o(valid_b_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Any flush request in cycles lo..hi (inclusive) wipes what was in flight.
  function automatic logic flushed(int lo, int hi);
    for (int k = (lo < 0 ? 0 : lo); k <= hi; k++) if (fl_h[k]) return 1'b1;
    return 1'b0;
  endfunction

  // A word presented in cycle t is taken when ensys is high and the bubble
  // flag raised BL cycles earlier survived to cycle t.
  function automatic logic accepted(int t);
    int k;
    logic bub;
    k = t - BL;
    bub = (k >= 0) ? (bub_h[k] && !flushed(k, t-1)) : 1'b0;
    return ens_h[t] && !bub;
  endfunction

  // Lane i in cycle n shows the word from cycle n-1-i if nothing flushed it.
  function automatic logic lane_ok(int n, int i);
    int t;
    t = n - 1 - i;
    if (t < 0) return 1'b0;
    return accepted(t) && !flushed(t, n-1);
  endfunction

  function automatic logic [LANES-1:0] exp_valid(int n);
    logic [LANES-1:0] v;
    for (int i = 0; i < LANES; i++) v[i] = lane_ok(n, i);
    return v;
  endfunction

  function automatic logic [W-1:0] exp_bus(int n, bit use_b);
    logic [W-1:0] r, src;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok(n, i)) begin
        src = use_b ? b_h[n-1-i] : a_h[n-1-i];
        r[i*DW +: DW] = src[i*DW +: DW];
      end
    end
    return r;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge) and record them.
  task automatic applyStimulus(input logic ens, input logic bub, input logic fl,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    if (cyc >= MAXC) begin
      $display("[TB] FAIL history overflow cyc=%0d limit=%0d", cyc, MAXC);
      failures++;
      $fatal(1, "[TB] history overflow");
    end
    ensys_i = ens; bubble_i = bub; flush_i = fl; data_a_i = a; data_b_i = b;
    ens_h[cyc] = ens; bub_h[cyc] = bub; fl_h[cyc] = fl; a_h[cyc] = a; b_h[cyc] = b;
    #1;
    ea = exp_bus(cyc, 1'b0);
    eb = exp_bus(cyc, 1'b1);
    ev = exp_valid(cyc);
    ebusy = ens | (|ev);
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    ensys_i = 1'b0; bubble_i = 1'b0; flush_i = 1'b0; data_a_i = '0; data_b_i = '0;
    #3;
    tests_run++;
    if ({a_o, b_o, valid_a_o, valid_b_o, busy_o} !== '0) begin
      failures++; $display("[TB] FAIL reset_state got a=%h b=%h va=%b vb=%b busy=%b required all 0",
                           a_o, b_o, valid_a_o, valid_b_o, busy_o);
    end
    @(posedge clk_i); @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1; cyc = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, rand_word(), rand_word());
      tests_run++;
      if ({a_o, b_o, valid_a_o, valid_b_o, busy_o} !== '0) begin
        failures++; $display("[TB] FAIL idle cyc=%0d got a=%h va=%b busy=%b required 0", cyc, a_o, valid_a_o, busy_o);
      end
      advance();
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] wa, wb;
    for (int i = 0; i < LANES; i++) begin
      wa[i*DW +: DW] = DW'(i + 1);
      wb[i*DW +: DW] = DW'(8'h11 * (i + 1));
    end
    for (int n = 0; n < 12; n++) begin
      applyStimulus(n == 1, 1'b0, 1'b0, wa, wb);
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL single a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL single b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL single valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL single busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      advance();
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] wa;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < LANES; i++) wa[i*DW +: DW] = DW'(cyc);
      applyStimulus(n >= 1 && n <= 4, 1'b0, 1'b0, wa, rand_word());
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL stream a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL stream b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL stream valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL stream busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      advance();
    end
  endtask

  task automatic test_bubbles();
    for (int n = 0; n < 20; n++) begin
      applyStimulus(n >= 1 && n <= 8, n >= 3 && n <= 7, 1'b0, rand_word(), rand_word());
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL bubble a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL bubble b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL bubble valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL bubble busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int n = 0; n < 14; n++) begin
      applyStimulus(n == 1 || n == 4, 1'b0, n == 4, rand_word(), rand_word());
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL flush a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL flush b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL flush valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL flush busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      if (n >= 5) begin
        tests_run++;
        if ({a_o, b_o, valid_a_o, busy_o} !== '0) begin
          failures++; $display("[TB] FAIL flush_clear cyc=%0d got a=%h va=%b busy=%b required 0", cyc, a_o, valid_a_o, busy_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, rand_word(), rand_word());
      advance();
    end
    ensys_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    tests_run++;
    if ({a_o, b_o, valid_a_o, valid_b_o, busy_o} !== '0) begin
      failures++; $display("[TB] FAIL async_reset got a=%h va=%b busy=%b required 0 before any edge", a_o, valid_a_o, busy_o);
    end
    @(posedge clk_i); @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1; cyc = 0;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(n == 2, 1'b0, 1'b0, rand_word(), rand_word());
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL post_reset a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL post_reset b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL post_reset valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL post_reset busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic ens, bub, fl;
    for (int n = 0; n < 330; n++) begin
      if (n < 20) begin
        ens = 1'b1; bub = 1'b0; fl = 1'b0;
      end else if (n < 310) begin
        ens = ($urandom_range(0, 3) != 0);
        bub = ($urandom_range(0, 3) == 0);
        fl  = ($urandom_range(0, 24) == 0);
      end else begin
        ens = 1'b0; bub = 1'b0; fl = 1'b0;
      end
      applyStimulus(ens, bub, fl, rand_word(), rand_word());
      tests_run++; if (a_o !== ea) begin failures++; $display("[TB] FAIL b2b a_o cyc=%0d got %h want %h", cyc, a_o, ea); end
      tests_run++; if (b_o !== eb) begin failures++; $display("[TB] FAIL b2b b_o cyc=%0d got %h want %h", cyc, b_o, eb); end
      tests_run++; if (valid_a_o !== ev || valid_b_o !== ev) begin failures++; $display("[TB] FAIL b2b valid cyc=%0d got %b/%b want %b", cyc, valid_a_o, valid_b_o, ev); end
      tests_run++; if (busy_o !== ebusy) begin failures++; $display("[TB] FAIL b2b busy cyc=%0d got %b want %b", cyc, busy_o, ebusy); end
      advance();
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_bubbles();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
